htif_uart_rx: RTL and testbench

HTIF_UART_RX -- requirements
Module: htif_uart_rx

---
 rtl/htif_uart_rx.sv | 164 ++++++++++++++++
 tb/tb_htif_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/htif_uart_rx.sv
// HTIF UART receiver: 8N1 deserializer feeding a small byte FIFO.
// Bad stop bits pulse framing_error; bytes arriving to a full FIFO pulse overrun.
module htif_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_LOG2    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic                 framing_error,
  output logic                 overrun,
  output logic [FIFO_LOG2:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                sync1_q, sync2_q;
  logic                fe_q, fe_d;
  logic                ovr_q, ovr_d;
  logic                push, pop, accept, full, tick, line;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_q, rd_q;
  logic [FIFO_LOG2:0]   cnt_q, cnt_d;

  assign line = sync2_q;
  assign tick = (timer_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!line) begin
          timer_d = HALF_T;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else if (!line) begin
          timer_d = FULL_T;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shift_d = {line, shift_q[7:1]};
          timer_d = FULL_T;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          timer_d = timer_q - 1'b1;
        end else begin
          push    = line;
          fe_d    = !line;
          state_d = line ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign full   = (cnt_q == DEPTH_C);
  assign pop    = rx_valid & rx_ready;
  assign accept = push & (!full | pop);
  assign ovr_d  = push & !accept;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign rx_valid      = (cnt_q != '0);
  assign rx_data       = rx_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_count    = cnt_q;
  assign framing_error = fe_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_htif_uart_rx.sv
// Directed bench for htif_uart_rx at CLKS_PER_BIT=4, FIFO_LOG2=2.
// Inputs change on the falling edge; the monitor samples 1ns before rising.
module tb_htif_uart_rx;

  logic       clock;
  logic       reset;
  logic       serial_in;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       framing_error;
  logic       overrun;
  logic [2:0] fifo_count;

  htif_uart_rx #(
    .CLKS_PER_BIT(4),
    .FIFO_LOG2   (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .framing_error(framing_error),
    .overrun      (overrun),
    .fifo_count   (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got[$];
  int fe_n, ovr_n, valid_n, both_n;

  always @(negedge clock) begin
    #4;
    if (reset) begin
      if (rx_valid) valid_n++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (framing_error) fe_n++;
      if (overrun) ovr_n++;
      if (framing_error && overrun) both_n++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    got.delete();
    fe_n    = 0;
    ovr_n   = 0;
    valid_n = 0;
  endtask

  function automatic int head(input int i);
    if (i < got.size()) return int'(got[i]);
    return -1;
  endfunction

  // Leaves the line at the stop-bit value, 40 falling edges after start.
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      serial_in = f[k];
      repeat (4) @(negedge clock);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         n_bytes;
    int         n_fe;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] exp_q[5];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 1, 0};
    both_n    = 0;
    clear();
    reset     = 1'b0;
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_fe", int'(framing_error), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_count", int'(fifo_count), 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clear();
      send(vecs[i].data, vecs[i].stop);
      serial_in = 1'b1;
      repeat (10) @(negedge clock);
      check($sformatf("v%0d_bytes", i), got.size(), vecs[i].n_bytes);
      check($sformatf("v%0d_vcyc", i), valid_n, vecs[i].n_bytes);
      if (vecs[i].n_bytes > 0)
        check($sformatf("v%0d_data", i), head(0), int'(vecs[i].data));
      check($sformatf("v%0d_fe", i), fe_n, vecs[i].n_fe);
      check($sformatf("v%0d_ovr", i), ovr_n, 0);
      check($sformatf("v%0d_count", i), int'(fifo_count), 0);
    end

    clear();
    serial_in = 1'b0;
    @(negedge clock);
    serial_in = 1'b1;
    repeat (12) @(negedge clock);
    check("glitch_valid", valid_n, 0);
    check("glitch_fe", fe_n, 0);
    check("glitch_ovr", ovr_n, 0);
    send(8'h96, 1'b1);
    serial_in = 1'b1;
    repeat (10) @(negedge clock);
    check("glitch_next_n", got.size(), 1);
    check("glitch_next_d", head(0), 'h96);

    clear();
    send(8'h3C, 1'b0);
    repeat (20) @(negedge clock);
    serial_in = 1'b1;
    repeat (4) @(negedge clock);
    send(8'h42, 1'b1);
    serial_in = 1'b1;
    repeat (10) @(negedge clock);
    check("brk_fe", fe_n, 1);
    check("brk_n", got.size(), 1);
    check("brk_d", head(0), 'h42);

    clear();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      serial_in = 1'b1;
      repeat (2) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    check("ovr_count", int'(fifo_count), 4);
    check("ovr_pulse", ovr_n, 1);
    rx_ready = 1'b1;
    repeat (10) @(negedge clock);
    check("ovr_n", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovr_d%0d", i), head(i), i + 1);
    check("ovr_empty", int'(fifo_count), 0);

    clear();
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'h11 + 8'(i), 1'b1);
      serial_in = 1'b1;
      repeat (2) @(negedge clock);
    end
    repeat (2) @(negedge clock);
    check("fp_full", int'(fifo_count), 4);
    send(8'h77, 1'b1);
    rx_ready  = 1'b1;
    serial_in = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    check("fp_count", int'(fifo_count), 4);
    repeat (4) @(negedge clock);
    check("fp_ovr", ovr_n, 0);
    rx_ready = 1'b1;
    repeat (10) @(negedge clock);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
    check("fp_n", got.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fp_d%0d", i), head(i), int'(exp_q[i]));

    clear();
    serial_in = 1'b0;
    repeat (4) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      serial_in = 1'b1;
      repeat (4) @(negedge clock);
    end
    serial_in = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mr_valid", int'(rx_valid), 0);
    check("mr_data", int'(rx_data), 0);
    check("mr_fe", int'(framing_error), 0);
    check("mr_ovr", int'(overrun), 0);
    check("mr_count", int'(fifo_count), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    send(8'h5A, 1'b1);
    serial_in = 1'b1;
    repeat (10) @(negedge clock);
    check("mr_n", got.size(), 1);
    check("mr_d", head(0), 'h5A);
    check("mr_fe_n", fe_n, 0);
    check("both_pulse", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
